rv3n_func_branch: RTL

- Parametrised next-generation branch/jump resolution unit for the rv3n execute stage.
- Resolves conditional branches, JAL and JALR, and produces the link value (pc+2 or pc+4).
- Issues a front-end redirect on mispredict or JALR, with the correct fall-through target when a predicted-taken branch is not taken.
- Sends predictor training, squashes younger wrong-path work, and buffers acks in a small FIFO with ready backpressure.

---
 rtl/rv3n_func_branch_pkg.sv | 24 ++
 rtl/rv3n_ack_fifo.sv | 60 ++++++
 rtl/rv3n_func_branch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv3n_func_branch_pkg.sv
// Shared definitions for the rv3n branch/jump resolution unit: request
// parameter layout and condition encodings.
package rv3n_func_branch_pkg;

  localparam int unsigned PARA_W = 8;

  localparam logic [2:0] COND_EQ  = 3'd0;
  localparam logic [2:0] COND_NE  = 3'd1;
  localparam logic [2:0] COND_LT  = 3'd2;
  localparam logic [2:0] COND_GE  = 3'd3;
  localparam logic [2:0] COND_LTU = 3'd4;
  localparam logic [2:0] COND_GEU = 3'd5;

  // Request parameter byte, MSB first.
  typedef struct packed {
    logic       predict;
    logic       compressed;
    logic       link;
    logic       jalr;
    logic       jal;
    logic [2:0] cond;
  } br_para_t;

endpackage

// File: rtl/rv3n_ack_fifo.sv
// Generic valid/ready FIFO with occupancy count and synchronous flush.
module rv3n_ack_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           push_valid_i,
  input  logic [WIDTH-1:0]               push_data_i,
  output logic                           pop_valid_o,
  input  logic                           pop_ready_i,
  output logic [WIDTH-1:0]               pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  assign pop_valid_o = (count_q != '0);
  assign pop         = pop_valid_o & pop_ready_i;
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_valid_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)          rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_valid_i) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_valid_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rv3n_func_branch.sv
// rv3n execute-stage branch/jump resolution: redirect, predictor training
// and buffered link acks. Optional RV3N_BRANCH_MISALIGN_EN adds a misaligned-target check.
module rv3n_func_branch
  import rv3n_func_branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IMM_W     = 21,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned ACK_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              func_branch_req_valid,
  input  logic [PARA_W-1:0] func_branch_req_para,
  input  logic [IMM_W-1:0]  func_branch_req_imm,
  input  logic [XLEN-1:0]   func_branch_req_pc,
  input  logic [XLEN-1:0]   func_branch_req_operand0,
  input  logic [XLEN-1:0]   func_branch_req_operand1,
  output logic              func_branch_req_busy,
  output logic              func_branch_ack_valid,
  input  logic              func_branch_ack_ready,
  output logic [XLEN-1:0]   func_branch_ack_data,
  output logic              jump_branch_valid,
  output logic [XLEN-1:0]   jump_branch_pc,
  output logic              ch2predictor_valid,
  output logic [XLEN-1:0]   ch2predictor_pc,
  output logic              ch2predictor_predict,
  output logic              ch2predictor_taken
`ifdef RV3N_BRANCH_MISALIGN_EN
  ,
  output logic              func_branch_misalign
`endif
);

  localparam int unsigned CNT_W = $clog2(ACK_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  function automatic logic cond_taken(input br_para_t p,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic t;
    t = 1'b0;
    if (p.jal || p.jalr) begin
      t = 1'b1;
    end else begin
      case (p.cond)
        COND_EQ:  t = (a == b);
        COND_NE:  t = (a != b);
        COND_LT:  t = ($signed(a) <  $signed(b));
        COND_GE:  t = ($signed(a) >= $signed(b));
        COND_LTU: t = (a <  b);
        COND_GEU: t = (a >= b);
        default:  t = 1'b0;
      endcase
    end
    return t;
  endfunction

  br_para_t         req_para;
  logic [XLEN-1:0]  req_simm;
  logic             req_taken;
  logic             accept;
  logic             fire_jump;
  logic             push;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       inflight;
  logic [OCC_W-1:0] occupancy;

  // Inputs to the final (add/resolve) stage
  logic             src_valid;
  br_para_t         src_para;
  logic             src_taken;
  logic [XLEN-1:0]  src_pc;
  logic [XLEN-1:0]  src_op0;
  logic [XLEN-1:0]  src_simm;

  logic             fin_valid_q,    fin_valid_d;
  logic             fin_redirect_q, fin_redirect_d;
  logic             fin_branch_q,   fin_branch_d;
  logic             fin_predict_q;
  logic             fin_taken_q;
  logic [XLEN-1:0]  fin_pc_q;
  logic [XLEN-1:0]  fin_jpc_q,      fin_jpc_d;
  logic [XLEN-1:0]  fin_ack_q,      fin_ack_d;
  logic [XLEN-1:0]  link_val;
  logic [XLEN-1:0]  target;
`ifdef RV3N_BRANCH_MISALIGN_EN
  logic             fin_misalign_q, fin_misalign_d;
`endif

  assign req_para  = br_para_t'(func_branch_req_para);
  assign req_simm  = XLEN'($signed(func_branch_req_imm));
  assign req_taken = cond_taken(req_para, func_branch_req_operand0, func_branch_req_operand1);

  // Busy looks only at registered occupancy so it never depends on this cycle's events.
  assign occupancy            = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign func_branch_req_busy = (occupancy >= OCC_W'(ACK_DEPTH));
  assign fire_jump            = fin_valid_q & fin_redirect_q & ~flush;
  assign accept               = func_branch_req_valid & ~func_branch_req_busy & ~flush & ~fire_jump;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic            s1_valid_q, s1_valid_d;
      br_para_t        s1_para_q;
      logic            s1_taken_q;
      logic [XLEN-1:0] s1_pc_q, s1_op0_q, s1_simm_q;

      assign s1_valid_d = accept;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_para_q  <= '0;
          s1_taken_q <= 1'b0;
          s1_pc_q    <= '0;
          s1_op0_q   <= '0;
          s1_simm_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          if (accept) begin
            s1_para_q  <= req_para;
            s1_taken_q <= req_taken;
            s1_pc_q    <= func_branch_req_pc;
            s1_op0_q   <= func_branch_req_operand0;
            s1_simm_q  <= req_simm;
          end
        end
      end

      // A redirect completing now squashes the younger stage-1 entry.
      assign src_valid = s1_valid_q & ~fire_jump & ~flush;
      assign src_para  = s1_para_q;
      assign src_taken = s1_taken_q;
      assign src_pc    = s1_pc_q;
      assign src_op0   = s1_op0_q;
      assign src_simm  = s1_simm_q;
      assign inflight  = 2'(s1_valid_q) + 2'(fin_valid_q);
    end else begin : g_one_stage
      assign src_valid = accept;
      assign src_para  = req_para;
      assign src_taken = req_taken;
      assign src_pc    = func_branch_req_pc;
      assign src_op0   = func_branch_req_operand0;
      assign src_simm  = req_simm;
      assign inflight  = 2'(fin_valid_q);
    end
  endgenerate

  // Target, link and redirect decision for the entry entering completion.
  always_comb begin
    fin_valid_d    = src_valid;
    link_val       = src_pc + (src_para.compressed ? XLEN'(2) : XLEN'(4));
    target         = (src_para.jalr ? src_op0 : src_pc) + src_simm;
    if (src_para.jalr) target[0] = 1'b0;
    fin_branch_d   = ~src_para.jal & ~src_para.jalr;
    fin_redirect_d = src_para.jalr | (src_para.jal & ~src_para.predict) |
                     (fin_branch_d & (src_para.predict != src_taken));
    fin_jpc_d      = src_taken ? target : link_val;
    fin_ack_d      = src_para.link ? link_val : '0;
`ifdef RV3N_BRANCH_MISALIGN_EN
    fin_misalign_d = src_taken & target[1];
    if (fin_misalign_d) begin
      fin_redirect_d = 1'b0;
      fin_ack_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_valid_q    <= 1'b0;
      fin_redirect_q <= 1'b0;
      fin_branch_q   <= 1'b0;
      fin_predict_q  <= 1'b0;
      fin_taken_q    <= 1'b0;
      fin_pc_q       <= '0;
      fin_jpc_q      <= '0;
      fin_ack_q      <= '0;
`ifdef RV3N_BRANCH_MISALIGN_EN
      fin_misalign_q <= 1'b0;
`endif
    end else begin
      fin_valid_q <= fin_valid_d;
      if (fin_valid_d) begin
        fin_redirect_q <= fin_redirect_d;
        fin_branch_q   <= fin_branch_d;
        fin_predict_q  <= src_para.predict;
        fin_taken_q    <= src_taken;
        fin_pc_q       <= src_pc;
        fin_jpc_q      <= fin_jpc_d;
        fin_ack_q      <= fin_ack_d;
`ifdef RV3N_BRANCH_MISALIGN_EN
        fin_misalign_q <= fin_misalign_d;
`endif
      end
    end
  end

  assign jump_branch_valid    = fire_jump;
  assign jump_branch_pc       = fin_jpc_q;
  assign ch2predictor_valid   = fin_valid_q & fin_branch_q & ~flush;
  assign ch2predictor_pc      = fin_pc_q;
  assign ch2predictor_predict = fin_predict_q;
  assign ch2predictor_taken   = fin_taken_q;
`ifdef RV3N_BRANCH_MISALIGN_EN
  assign func_branch_misalign = fin_valid_q & fin_misalign_q & ~flush;
`endif

  assign push = fin_valid_q & ~flush;

  rv3n_ack_fifo #(
    .DEPTH (ACK_DEPTH),
    .WIDTH (XLEN)
  ) u_ack_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_valid_i (push),
    .push_data_i  (fin_ack_q),
    .pop_valid_o  (func_branch_ack_valid),
    .pop_ready_i  (func_branch_ack_ready),
    .pop_data_o   (func_branch_ack_data),
    .count_o      (fifo_count)
  );

endmodule
